sine_index_dispatcher: RTL and testbench

Parametrised successor of the main-FPGA normal-mode sequencer. On every carrier period it requests one sine-table index from the SPI fetcher, then broadcasts it as two UART bytes to a masked set of `NUM_CH` module links. It also generates the `shoot` pulse and flags links that never start and periods that overrun. It sits between `SPI_request_data` and the per-channel `uart_tx` instances; it runs on the same clock as the UART TX blocks.

---
 rtl/sine_index_dispatcher.sv | 157 +++++++++++++++
 tb/tb_sine_index_dispatcher.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_index_dispatcher.sv
// Per-period sine index dispatcher: fetches one index per carrier period and
// broadcasts it as two UART bytes to a masked set of links, with fire window.
//
// state      | meaning
// S_IDLE     | waiting for period tick
// S_REQ      | fetch request pulse, latch active channel set
// S_WAIT_IDX | waiting for fetched index
// S_SEND1    | byte 1 start held until all active links went busy
// S_DRAIN1   | waiting for active links to finish byte 1
// S_SEND2    | byte 2 start held until all active links went busy
// S_DRAIN2   | waiting for active links to finish byte 2
// S_DONE     | frame complete pulse
module sine_index_dispatcher #(
    parameter int NUM_CH    = 9,
    parameter int PERIOD    = 2400,
    parameter int SHOOT_LEN = 100,
    parameter int START_TO  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              req,
    input  logic              idx_valid,
    input  logic [11:0]       sin_index,
    input  logic [3:0]        uart_id,
    output logic [7:0]        data_to_tx,
    output logic [NUM_CH-1:0] start_tx,
    input  logic [NUM_CH-1:0] tx_busy,
    output logic              shoot,
    output logic              frame_done,
    output logic [NUM_CH-1:0] tx_fault,
    output logic              overrun
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TW = $clog2(START_TO + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(START_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_IDX, S_SEND1, S_DRAIN1, S_SEND2, S_DRAIN2, S_DONE
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [TW-1:0]     to_cnt, to_n;
    logic [NUM_CH-1:0] act, act_n, seen, seen_n, seen_all, fault_n;
    logic [11:0]       idx_l, idx_n;
    logic [3:0]        id_l, id_n;
    logic              tick, ovr_n;

    assign tick = enable && (cnt == CNT_LAST);

    always_comb begin
        cnt_n = '0;
        if (enable) begin
            cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
    end

    always_comb begin
        state_n  = state;
        act_n    = act;
        seen_n   = seen;
        to_n     = to_cnt;
        idx_n    = idx_l;
        id_n     = id_l;
        fault_n  = tx_fault;
        seen_all = seen | (tx_busy & act);
        // a tick while a frame is in flight is dropped, not queued
        ovr_n    = overrun | (tick && (state != S_IDLE));
        case (state)
            S_IDLE: begin
                if (tick) state_n = S_REQ;
            end
            S_REQ: begin
                act_n   = ch_mask & ~tx_fault;
                state_n = S_WAIT_IDX;
            end
            S_WAIT_IDX: begin
                if (idx_valid) begin
                    idx_n   = sin_index;
                    id_n    = uart_id;
                    seen_n  = '0;
                    to_n    = TO_LOAD;
                    state_n = S_SEND1;
                end
            end
            S_SEND1, S_SEND2: begin
                seen_n = seen_all;
                to_n   = to_cnt - TW'(1);
                if ((seen_all & act) == act) begin
                    state_n = (state == S_SEND1) ? S_DRAIN1 : S_DRAIN2;
                end else if (to_cnt == '0) begin
                    fault_n = tx_fault | (act & ~seen_all);
                    act_n   = act & seen_all;
                    state_n = (state == S_SEND1) ? S_DRAIN1 : S_DRAIN2;
                end
            end
            S_DRAIN1: begin
                if ((tx_busy & act) == '0) begin
                    seen_n  = '0;
                    to_n    = TO_LOAD;
                    state_n = S_SEND2;
                end
            end
            S_DRAIN2: begin
                if ((tx_busy & act) == '0) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // outputs are registered from the next-state values
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            to_cnt     <= '0;
            act        <= '0;
            seen       <= '0;
            idx_l      <= '0;
            id_l       <= '0;
            req        <= 1'b0;
            frame_done <= 1'b0;
            start_tx   <= '0;
            data_to_tx <= '0;
            shoot      <= 1'b0;
            tx_fault   <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            to_cnt     <= to_n;
            act        <= act_n;
            seen       <= seen_n;
            idx_l      <= idx_n;
            id_l       <= id_n;
            tx_fault   <= fault_n;
            overrun    <= ovr_n;
            req        <= (state_n == S_REQ);
            frame_done <= (state_n == S_DONE);
            shoot      <= enable && (cnt_n < CW'(SHOOT_LEN));
            start_tx   <= ((state_n == S_SEND1) || (state_n == S_SEND2)) ? act_n : '0;
            if (state_n == S_SEND1) begin
                data_to_tx <= {id_n, idx_n[11:8]};
            end else if (state_n == S_SEND2) begin
                data_to_tx <= idx_n[7:0];
            end
        end
    end
endmodule

// File: tb/tb_sine_index_dispatcher.sv
// Directed/randomized bench for sine_index_dispatcher with per-channel uart_tx
// models and an arithmetic model of period timing, bytes and faults.
module tb_sine_index_dispatcher;
    localparam int NUM_CH    = 9;
    localparam int PERIOD    = 200;
    localparam int SHOOT_LEN = 100;
    localparam int START_TO  = 64;

    logic              clk;
    logic              reset, enable, idx_valid;
    logic [NUM_CH-1:0] ch_mask, start_tx, tx_busy, tx_fault;
    logic [11:0]       sin_index;
    logic [3:0]        uart_id;
    logic [7:0]        data_to_tx;
    logic              req, shoot, frame_done, overrun;

    sine_index_dispatcher #(
        .NUM_CH(NUM_CH), .PERIOD(PERIOD), .SHOOT_LEN(SHOOT_LEN), .START_TO(START_TO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .req(req),
        .idx_valid(idx_valid), .sin_index(sin_index), .uart_id(uart_id),
        .data_to_tx(data_to_tx), .start_tx(start_tx), .tx_busy(tx_busy),
        .shoot(shoot), .frame_done(frame_done), .tx_fault(tx_fault), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n = 0, e0 = 0, n_checks = 0, n_errors = 0;
    int lat[NUM_CH], blen[NUM_CH], dly[NUM_CH], bcnt[NUM_CH];
    int rx_cnt[NUM_CH], rise_n[NUM_CH], fall_n[NUM_CH];
    logic [7:0] rx_b1[NUM_CH], rx_b2[NUM_CH];
    bit dead[NUM_CH];
    logic [NUM_CH-1:0] start_prev = '0, start_any = '0, fault_model = '0;
    int last_busy_n = 0, s2_gap = -1, req_cnt = 0, fd_cnt = 0, shoot_bad = 0, req_bad = 0;
    bit s2_seen = 1'b0, win_chk = 1'b0;

    // uart_tx models and event recorder, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        n++;
        if (reset) begin
            tx_busy    = '0;
            start_prev = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dly[i]  = 0;
                bcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (start_tx[i] && !start_prev[i]) begin
                    if (rx_cnt[i] == 0) rx_b1[i] = data_to_tx;
                    if (rx_cnt[i] == 1) rx_b2[i] = data_to_tx;
                    if (rx_cnt[i] == 1 && !s2_seen) begin
                        s2_seen = 1'b1;
                        s2_gap  = n - last_busy_n;
                    end
                    rx_cnt[i]++;
                    rise_n[i] = n;
                    if (!dead[i]) dly[i] = lat[i];
                end else if (dly[i] > 0) begin
                    dly[i]--;
                    if (dly[i] == 0) bcnt[i] = blen[i];
                end
                if (!start_tx[i] && start_prev[i]) fall_n[i] = n;
                tx_busy[i] = (bcnt[i] > 0);
                if (bcnt[i] > 0) bcnt[i]--;
            end
            if (tx_busy != '0) last_busy_n = n;
            start_prev = start_tx;
            start_any  = start_any | start_tx;
            if (req === 1'b1) req_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
            if (win_chk) begin
                if (shoot !== (enable && (((n - e0) % PERIOD) < SHOOT_LEN))) shoot_bad++;
                if (req !== (enable && (n > e0) && (((n - e0) % PERIOD) == 0))) req_bad++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_channels(input int lmax, input int bmin, input int bmax);
        for (int i = 0; i < NUM_CH; i++) begin
            lat[i]  = $urandom_range(lmax, 1);
            blen[i] = $urandom_range(bmax, bmin);
            dead[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        enable = 1'b0;
        idx_valid = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        fault_model = '0;
        tick();
    endtask

    task automatic start_enable();
        enable = 1'b1;
        e0 = n;
    endtask

    task automatic wait_req(output int rn);
        rn = -1;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            tick();
            if (req === 1'b1) begin
                rn = n;
                break;
            end
        end
    endtask

    task automatic clear_rx();
        for (int i = 0; i < NUM_CH; i++) begin
            rx_cnt[i] = 0;
            rise_n[i] = 0;
            fall_n[i] = 0;
        end
        s2_seen = 1'b0;
        s2_gap = -1;
        start_any = '0;
    endtask

    task automatic run_frame(input int dly_c, input logic [11:0] idx, input logic [3:0] id,
                             input logic [NUM_CH-1:0] act, output int t_idx, output int t_fd);
        repeat (dly_c) tick();
        sin_index = idx;
        uart_id = id;
        idx_valid = 1'b1;
        t_idx = n;
        tick();
        idx_valid = 1'b0;
        chk("start_after_idx", 32'(start_tx), 32'(act));
        chk("byte1_data", 32'(data_to_tx), 32'({id, idx[11:8]}));
        t_fd = -1;
        for (int k = 0; k < 4 * PERIOD; k++) begin
            if (frame_done === 1'b1) begin
                t_fd = n;
                break;
            end
            tick();
        end
    endtask

    task automatic check_bytes(input logic [NUM_CH-1:0] act, input logic [7:0] b1, input logic [7:0] b2);
        logic [NUM_CH-1:0] bad;
        bad = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int ec;
            ec = act[i] ? (dead[i] ? 1 : 2) : 0;
            if (rx_cnt[i] != ec || (ec >= 1 && rx_b1[i] !== b1) || (ec == 2 && rx_b2[i] !== b2))
                bad[i] = 1'b1;
        end
        chk("frame_bytes", 32'(bad), 32'(0));
    endtask

    initial begin
        int r, t, f, rq0, fd0, mxl, nxt;
        logic [NUM_CH-1:0] act;
        logic [11:0] idx;
        logic [3:0] id;

        reset = 1'b1; enable = 1'b0; idx_valid = 1'b0;
        ch_mask = '0; sin_index = '0; uart_id = '0;
        set_channels(3, 4, 12);
        repeat (3) tick();
        chk("rst_req", 32'(req), 0);
        chk("rst_start", 32'(start_tx), 0);
        chk("rst_data", 32'(data_to_tx), 0);
        chk("rst_shoot", 32'(shoot), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_fault", 32'(tx_fault), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        tick();

        // basic frames and shoot window over three periods
        ch_mask = '1;
        win_chk = 1'b1;
        start_enable();
        for (int k = 1; k <= 3; k++) begin
            wait_req(r);
            chk("req_period_start", 32'(r), 32'(e0 + k * PERIOD));
            clear_rx();
            fd0 = fd_cnt;
            act = ch_mask & ~fault_model;
            idx = (k == 1) ? 12'hABC : 12'($urandom);
            id  = (k == 1) ? 4'h5 : 4'($urandom);
            run_frame(3, idx, id, act, t, f);
            repeat (2) tick();
            chk("frame_done_once", 32'(fd_cnt - fd0), 1);
            check_bytes(act, {id, idx[11:8]}, idx[7:0]);
            if (k == 1) begin
                chk("basic_byte1", 32'(rx_b1[0]), 32'h5A);
                chk("basic_byte2", 32'(rx_b2[8]), 32'hBC);
            end
            chk("send2_after_last_busy", 32'(s2_gap), 2);
            mxl = 0;
            for (int i = 0; i < NUM_CH; i++) if (lat[i] > mxl) mxl = lat[i];
            chk("send_len", 32'(fall_n[0] - rise_n[0]), 32'(1 + mxl));
        end
        rq0 = req_cnt;
        enable = 1'b0;
        repeat (2 * PERIOD) tick();
        win_chk = 1'b0;
        chk("req_count_disabled", 32'(req_cnt), 32'(rq0));
        chk("shoot_window", 32'(shoot_bad), 0);
        chk("req_timing", 32'(req_bad), 0);
        chk("no_fault", 32'(tx_fault), 0);
        chk("no_overrun", 32'(overrun), 0);

        // dead channel 4
        do_reset();
        set_channels(3, 4, 12);
        dead[4] = 1'b1;
        ch_mask = '1;
        start_enable();
        for (int k = 1; k <= 2; k++) begin
            wait_req(r);
            chk("dead_req", 32'(r), 32'(e0 + k * PERIOD));
            clear_rx();
            act = ch_mask & ~fault_model;
            idx = 12'($urandom);
            id  = 4'($urandom);
            run_frame(2, idx, id, act, t, f);
            check_bytes(act, {id, idx[11:8]}, idx[7:0]);
            for (int i = 0; i < NUM_CH; i++) if (act[i] && dead[i]) fault_model[i] = 1'b1;
            chk("dead_fault_model", 32'(tx_fault), 32'(fault_model));
            if (k == 1) chk("dead_timeout_len", 32'(fall_n[4] - rise_n[4]), 32'(START_TO));
        end
        chk("dead_fault_exact", 32'(tx_fault), 32'h010);

        // skewed busy lengths
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            lat[i] = 1; blen[i] = 6 + i; dead[i] = 1'b0;
        end
        ch_mask = '1;
        start_enable();
        wait_req(r);
        clear_rx();
        act = ch_mask;
        idx = 12'($urandom);
        id  = 4'($urandom);
        run_frame(1, idx, id, act, t, f);
        check_bytes(act, {id, idx[11:8]}, idx[7:0]);
        chk("skew_gap", 32'(s2_gap), 2);
        chk("skew_send2_rise", 32'(rise_n[0]), 32'(t + 1 + 16));

        // overrun: index withheld across a tick
        do_reset();
        set_channels(3, 4, 12);
        ch_mask = '1;
        start_enable();
        wait_req(r);
        chk("ovr_req", 32'(r), 32'(e0 + PERIOD));
        rq0 = req_cnt;
        fd0 = fd_cnt;
        clear_rx();
        act = ch_mask;
        idx = 12'($urandom);
        id  = 4'($urandom);
        run_frame(PERIOD + 60, idx, id, act, t, f);
        chk("overrun_set", 32'(overrun), 1);
        check_bytes(act, {id, idx[11:8]}, idx[7:0]);
        nxt = e0 + PERIOD;
        while (nxt < f + 2) nxt += PERIOD;
        wait_req(r);
        chk("ovr_next_req", 32'(r), 32'(nxt));
        chk("ovr_one_frame", 32'(fd_cnt - fd0), 1);
        chk("ovr_req_count", 32'(req_cnt - rq0), 1);

        // reset during DRAIN1
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            lat[i] = 2; blen[i] = 20; dead[i] = 1'b0;
        end
        ch_mask = '1;
        start_enable();
        wait_req(r);
        clear_rx();
        sin_index = 12'($urandom);
        uart_id = 4'($urandom);
        idx_valid = 1'b1;
        tick();
        idx_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (start_tx === '0) break;
            tick();
        end
        tick();
        fd0 = fd_cnt;
        reset = 1'b1;
        tick();
        chk("mid_rst_req", 32'(req), 0);
        chk("mid_rst_start", 32'(start_tx), 0);
        chk("mid_rst_data", 32'(data_to_tx), 0);
        chk("mid_rst_shoot", 32'(shoot), 0);
        chk("mid_rst_frame_done", 32'(frame_done), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        enable = 1'b0;
        reset = 1'b0;
        clear_rx();
        repeat (40) tick();
        chk("mid_rst_abort", 32'(fd_cnt - fd0), 0);
        chk("mid_rst_no_start", 32'(start_any), 0);

        // empty mask
        ch_mask = '0;
        start_enable();
        wait_req(r);
        chk("empty_req", 32'(r), 32'(e0 + PERIOD));
        clear_rx();
        fd0 = fd_cnt;
        run_frame(1, 12'($urandom), 4'($urandom), '0, t, f);
        chk("empty_frame_len", 32'(f), 32'(t + 5));
        repeat (3) tick();
        chk("empty_fd_once", 32'(fd_cnt - fd0), 1);
        chk("empty_no_start", 32'(start_any), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
